// File: rtl/mm_pkg.sv
// ============================================================================
// Module  : mm_pkg
// Brief   : Shared types and constants for the result-RAM arbitration slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mm_pkg;

    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PEND   = 2'd1,
        RD_FLIGHT = 2'd2,
        RD_RET    = 2'd3
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter with enable and synchronous clear, sticks at all-ones.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/result_port_arbiter.sv
// ============================================================================
// Module  : result_port_arbiter
// Brief   : Shares the dual-port Result RAM between compute write-back and
//           host readout; compute has priority with a starvation guard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_port_arbiter
    import mm_pkg::*;
#(
    parameter int ADDR_WIDTH   = 7,
    parameter int RESULT_WIDTH = 24,
    parameter int RAM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addrA,
    input  logic [ADDR_WIDTH-1:0]   wr_addrB,
    input  logic [RESULT_WIDTH-1:0] wr_dataA,
    input  logic [RESULT_WIDTH-1:0] wr_dataB,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_busy,
    output logic                    rd_valid,
    output logic [RESULT_WIDTH-1:0] rd_data,
    output logic                    rd_overrun,
    output logic                    ram_write,
    output logic [ADDR_WIDTH-1:0]   ram_addrA,
    output logic [ADDR_WIDTH-1:0]   ram_addrB,
    output logic [RESULT_WIDTH-1:0] ram_dataA,
    output logic [RESULT_WIDTH-1:0] ram_dataB,
    input  logic [RESULT_WIDTH-1:0] ram_qA,
    output logic [STALL_W-1:0]      stall_count
);

    localparam int c_LAT_W    = $clog2(RAM_LAT + 1);
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);

    rd_state_t               r_state;
    rd_state_t               w_state_next;
    logic [c_LAT_W-1:0]      r_lat_cnt;
    logic [c_STARVE_W-1:0]   r_starve_cnt;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [RESULT_WIDTH-1:0] r_rd_data;
    logic                    r_rd_overrun;
    logic                    r_ram_write;
    logic [ADDR_WIDTH-1:0]   r_ram_addrA;
    logic [ADDR_WIDTH-1:0]   r_ram_addrB;
    logic [RESULT_WIDTH-1:0] r_ram_dataA;
    logic [RESULT_WIDTH-1:0] r_ram_dataB;
    logic                    w_host_gnt;
    logic                    w_wr_ready;
    logic                    w_wr_beat;
    logic                    w_rd_accept;

    assign w_host_gnt  = (r_state == RD_PEND) &&
                         (!wr_valid || (r_starve_cnt >= c_STARVE_W'(STARVE_LIMIT)));
    // Held low during reset so every output reads zero while reset is asserted.
    assign w_wr_ready  = !w_host_gnt && !reset;
    assign w_wr_beat   = wr_valid && w_wr_ready;
    assign w_rd_accept = (r_state == RD_IDLE) && rd_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RD_IDLE:   if (rd_req)              w_state_next = RD_PEND;
            RD_PEND:   if (w_host_gnt)          w_state_next = RD_FLIGHT;
            RD_FLIGHT: if (r_lat_cnt == '0)     w_state_next = RD_RET;
            RD_RET:                             w_state_next = RD_IDLE;
            default:                            w_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_rd_addr    <= '0;
            r_rd_data    <= '0;
            r_rd_overrun <= 1'b0;
        end else begin
            if (w_rd_accept) begin
                r_rd_addr <= rd_addr;
            end
            if (rd_req && (r_state != RD_IDLE)) begin
                r_rd_overrun <= 1'b1;
            end
            if ((r_state == RD_PEND) && !w_host_gnt) begin
                r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
            end else begin
                r_starve_cnt <= '0;
            end
            // Latency counter reaches zero exactly when ram_qA carries our word.
            if (w_host_gnt) begin
                r_lat_cnt <= c_LAT_W'(RAM_LAT);
            end else if (r_state == RD_FLIGHT) begin
                if (r_lat_cnt == '0) begin
                    r_rd_data <= ram_qA;
                end else begin
                    r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ram_write <= 1'b0;
            r_ram_addrA <= '0;
            r_ram_addrB <= '0;
            r_ram_dataA <= '0;
            r_ram_dataB <= '0;
        end else if (w_wr_beat) begin
            r_ram_write <= 1'b1;
            r_ram_addrA <= wr_addrA;
            r_ram_addrB <= wr_addrB;
            r_ram_dataA <= wr_dataA;
            r_ram_dataB <= wr_dataB;
        end else if (w_host_gnt) begin
            r_ram_write <= 1'b0;
            r_ram_addrA <= r_rd_addr;
            r_ram_addrB <= '0;
        end else begin
            r_ram_write <= 1'b0;
        end
    end

    sat_counter #(
        .W (STALL_W)
    ) u_stall_cnt (
        .clk     (clock),
        .i_clr   (reset),
        .i_en    (wr_valid && !w_wr_ready),
        .o_count (stall_count)
    );

    assign wr_ready   = w_wr_ready;
    assign rd_busy    = (r_state != RD_IDLE);
    assign rd_valid   = (r_state == RD_RET);
    assign rd_data    = r_rd_data;
    assign rd_overrun = r_rd_overrun;
    assign ram_write  = r_ram_write;
    assign ram_addrA  = r_ram_addrA;
    assign ram_addrB  = r_ram_addrB;
    assign ram_dataA  = r_ram_dataA;
    assign ram_dataB  = r_ram_dataB;

endmodule

`default_nettype wire

// File: tb/tb_result_port_arbiter.sv
// ============================================================================
// Module  : tb_result_port_arbiter
// Brief   : Directed self-checking bench for result_port_arbiter with a RAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_result_port_arbiter;

    logic        clock;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [6:0]  wr_addrA;
    logic [6:0]  wr_addrB;
    logic [23:0] wr_dataA;
    logic [23:0] wr_dataB;
    logic        rd_req;
    logic [6:0]  rd_addr;
    logic        rd_busy;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic        rd_overrun;
    logic        ram_write;
    logic [6:0]  ram_addrA;
    logic [6:0]  ram_addrB;
    logic [23:0] ram_dataA;
    logic [23:0] ram_dataB;
    logic [23:0] ram_qA;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    logic [23:0] mem [0:127];

    result_port_arbiter #(
        .ADDR_WIDTH   (7),
        .RESULT_WIDTH (24),
        .RAM_LAT      (1),
        .STARVE_LIMIT (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addrA    (wr_addrA),
        .wr_addrB    (wr_addrB),
        .wr_dataA    (wr_dataA),
        .wr_dataB    (wr_dataB),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_busy     (rd_busy),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_overrun  (rd_overrun),
        .ram_write   (ram_write),
        .ram_addrA   (ram_addrA),
        .ram_addrB   (ram_addrB),
        .ram_dataA   (ram_dataA),
        .ram_dataB   (ram_dataB),
        .ram_qA      (ram_qA),
        .stall_count (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-cycle-latency dual-port RAM; read-before-write on port A.
    always @(posedge clock) begin
        if (ram_write) begin
            mem[ram_addrA] <= ram_dataA;
            mem[ram_addrB] <= ram_dataB;
        end
        ram_qA <= mem[ram_addrA];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nvalid;

        // Reset held with both requesters active
        reset = 1'b1; wr_valid = 1'b1; rd_req = 1'b1; rd_addr = 7'd9;
        wr_addrA = 7'd1; wr_addrB = 7'd2; wr_dataA = 24'h123456; wr_dataB = 24'h654321;
        repeat (3) begin
            next_cycle();
            @(negedge clock);
            check("rst_ram_write", 32'(ram_write), 32'd0);
            check("rst_busy", 32'(rd_busy), 32'd0);
            check("rst_wr_ready", 32'(wr_ready), 32'd0);
        end
        next_cycle();
        reset = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
        @(negedge clock);
        check("rel_ram_write", 32'(ram_write), 32'd0);
        check("rel_ram_addrA", 32'(ram_addrA), 32'd0);
        check("rel_ram_addrB", 32'(ram_addrB), 32'd0);
        check("rel_ram_dataA", 32'(ram_dataA), 32'd0);
        check("rel_ram_dataB", 32'(ram_dataB), 32'd0);
        check("rel_busy", 32'(rd_busy), 32'd0);
        check("rel_valid", 32'(rd_valid), 32'd0);
        check("rel_rd_data", 32'(rd_data), 32'd0);
        check("rel_overrun", 32'(rd_overrun), 32'd0);
        check("rel_stall", 32'(stall_count), 32'd0);

        // Single write beat
        next_cycle();
        wr_valid = 1'b1; wr_addrA = 7'd5; wr_addrB = 7'd6;
        wr_dataA = 24'h0000AA; wr_dataB = 24'h0000BB;
        @(negedge clock);
        check("wr_ready", 32'(wr_ready), 32'd1);
        next_cycle();
        wr_valid = 1'b0;
        @(negedge clock);
        check("wr_ram_write", 32'(ram_write), 32'd1);
        check("wr_addrA", 32'(ram_addrA), 32'd5);
        check("wr_addrB", 32'(ram_addrB), 32'd6);
        check("wr_dataA", 32'(ram_dataA), 32'h0000AA);
        check("wr_dataB", 32'(ram_dataB), 32'h0000BB);
        next_cycle();
        @(negedge clock);
        check("wr_done_write", 32'(ram_write), 32'd0);
        check("wr_hold_addrA", 32'(ram_addrA), 32'd5);

        // Idle read of address 5
        next_cycle();
        rd_req = 1'b1; rd_addr = 7'd5;
        @(negedge clock);
        check("rd_c0_busy", 32'(rd_busy), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            rd_req = 1'b0;
            @(negedge clock);
            check($sformatf("rd_c%0d_busy", c), 32'(rd_busy), (c <= 4) ? 32'd1 : 32'd0);
            check($sformatf("rd_c%0d_valid", c), 32'(rd_valid), (c == 4) ? 32'd1 : 32'd0);
            if (c == 2) begin
                check("rd_c2_addrA", 32'(ram_addrA), 32'd5);
                check("rd_c2_addrB", 32'(ram_addrB), 32'd0);
                check("rd_c2_write", 32'(ram_write), 32'd0);
            end
            if (c >= 4) check($sformatf("rd_c%0d_data", c), 32'(rd_data), 32'h0000AA);
        end

        // Starvation guard under continuous compute traffic
        next_cycle();
        wr_valid = 1'b1; wr_addrA = 7'd20; wr_addrB = 7'd21;
        wr_dataA = 24'h111111; wr_dataB = 24'h222222;
        rd_req = 1'b1; rd_addr = 7'd6;
        @(negedge clock);
        check("st_c0_ready", 32'(wr_ready), 32'd1);
        check("st_c0_stall", 32'(stall_count), 32'd0);
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            rd_req = 1'b0;
            if (c >= 7) wr_valid = 1'b0;
            @(negedge clock);
            if (c <= 4) check($sformatf("st_c%0d_ready", c), 32'(wr_ready), 32'd1);
            if (c == 5) begin
                check("st_c5_ready", 32'(wr_ready), 32'd0);
                check("st_c5_stall", 32'(stall_count), 32'd0);
            end
            if (c == 6) begin
                check("st_c6_ready", 32'(wr_ready), 32'd1);
                check("st_c6_stall", 32'(stall_count), 32'd1);
                check("st_c6_addrA", 32'(ram_addrA), 32'd6);
                check("st_c6_write", 32'(ram_write), 32'd0);
            end
            check($sformatf("st_c%0d_valid", c), 32'(rd_valid), (c == 8) ? 32'd1 : 32'd0);
            if (c == 8) check("st_c8_data", 32'(rd_data), 32'h0000BB);
        end
        check("st_stall_final", 32'(stall_count), 32'd1);

        // Overrun: second request while the first is in flight
        next_cycle();
        rd_req = 1'b1; rd_addr = 7'd5;
        @(negedge clock);
        check("ov_c0_overrun", 32'(rd_overrun), 32'd0);
        nvalid = 0;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            rd_req = (c == 2);
            rd_addr = (c == 2) ? 7'd21 : 7'd5;
            @(negedge clock);
            if (rd_valid) begin
                nvalid++;
                check($sformatf("ov_c%0d_data", c), 32'(rd_data), 32'h0000AA);
            end
            if (c == 2) check("ov_c2_overrun", 32'(rd_overrun), 32'd0);
            if (c == 3) check("ov_c3_overrun", 32'(rd_overrun), 32'd1);
            if (c == 4) check("ov_c4_valid", 32'(rd_valid), 32'd1);
        end
        check("ov_nvalid", 32'(nvalid), 32'd1);
        check("ov_sticky", 32'(rd_overrun), 32'd1);

        // Reset during the flight cycle
        next_cycle();
        rd_req = 1'b1; rd_addr = 7'd6;
        next_cycle();
        rd_req = 1'b0;
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        check("rf_c2_busy", 32'(rd_busy), 32'd1);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("rf_busy", 32'(rd_busy), 32'd0);
        check("rf_overrun", 32'(rd_overrun), 32'd0);
        check("rf_addrA", 32'(ram_addrA), 32'd0);
        nvalid = (rd_valid === 1'b1) ? 1 : 0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            @(negedge clock);
            if (rd_valid) nvalid++;
        end
        check("rf_nvalid", 32'(nvalid), 32'd0);
        check("rf_idle_busy", 32'(rd_busy), 32'd0);

        // Normal read after the aborted one
        next_cycle();
        rd_req = 1'b1; rd_addr = 7'd5;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            rd_req = 1'b0;
            @(negedge clock);
            check($sformatf("rr_c%0d_valid", c), 32'(rd_valid), (c == 4) ? 32'd1 : 32'd0);
            if (c == 4) check("rr_c4_data", 32'(rd_data), 32'h0000AA);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
